// File: rtl/gba_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gba_mem_arbiter
// Purpose  : Shares the single byte-wide SDRAM request port between the ROM
//            loader (writes), the GBA cart bus (ROM reads) and backup/save
//            RAM (reads and writes). Only one SDRAM transaction is in flight
//            at a time. One loader byte is buffered and hps_io is throttled
//            through ld_wait. A watchdog forces completion if the SDRAM
//            controller never answers.
// Ports    : clk_sys, reset_n (async, active-low)
//            loader : downloading, ld_wr, ld_addr, ld_data -> ld_wait
//            cart   : cart_req, cart_addr -> cart_ack, cart_dout
//            save   : sv_req, sv_we, sv_addr, sv_din -> sv_ack, sv_dout
//            sdram  : mem_req, mem_we, mem_addr, mem_din <- mem_ack, mem_dout
//            status : timeout_err (sticky until reset)
// Revision : 1.0 - initial release
// ============================================================================
module gba_mem_arbiter #(
    parameter int                ADDR_W    = 25,
    parameter logic [ADDR_W-1:0] SAVE_BASE = 25'h1F00000,
    parameter int                TIMEOUT   = 255
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    // loader
    input  logic              downloading,
    input  logic              ld_wr,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              ld_wait,
    // cart ROM read port
    input  logic              cart_req,
    input  logic [ADDR_W-1:0] cart_addr,
    output logic              cart_ack,
    output logic [7:0]        cart_dout,
    // save RAM port
    input  logic              sv_req,
    input  logic              sv_we,
    input  logic [ADDR_W-1:0] sv_addr,
    input  logic [7:0]        sv_din,
    output logic              sv_ack,
    output logic [7:0]        sv_dout,
    // sdram controller
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic              mem_ack,
    input  logic [7:0]        mem_dout,
    // status
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_LD   = 2'd0,
        OWN_CART = 2'd1,
        OWN_SV   = 2'd2
    } owner_t;

    // Last WAIT cycle count before the watchdog forces completion.
    localparam logic [7:0] c_WD_LAST = 8'(TIMEOUT - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t              state_q,     state_d;
    owner_t              owner_q,     owner_d;
    logic                last_sv_q,   last_sv_d;   // 1 = sv served last among sv/cart
    logic                ld_full_q,   ld_full_d;
    logic [ADDR_W-1:0]   ld_addr_q,   ld_addr_d;
    logic [7:0]          ld_data_q,   ld_data_d;
    logic                mem_req_q,   mem_req_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [7:0]          mem_din_q,   mem_din_d;
    logic                cart_ack_q,  cart_ack_d;
    logic [7:0]          cart_dout_q, cart_dout_d;
    logic                sv_ack_q,    sv_ack_d;
    logic [7:0]          sv_dout_q,   sv_dout_d;
    logic [7:0]          wd_cnt_q,    wd_cnt_d;
    logic                terr_q,      terr_d;

    // ------------------------------------------------------------------------
    // Arbitration helpers (only acted on in IDLE)
    // ------------------------------------------------------------------------
    logic                w_host_ok;
    logic                w_pick_sv;
    logic                w_pick_cart;
    logic [ADDR_W-1:0]   w_sv_mem_addr;
    logic                w_finish;
    logic [7:0]          w_rd_data;

    // The loader buffer always wins; cart/save are only eligible when the
    // loader does not own memory and its buffer is empty.
    assign w_host_ok     = !downloading && !ld_full_q;
    // On a tie the port served last yields.
    assign w_pick_sv     = w_host_ok && sv_req && (!cart_req || !last_sv_q);
    assign w_pick_cart   = w_host_ok && cart_req && !w_pick_sv;
    // Sum is evaluated at ADDR_W bits, so it wraps at the top of memory.
    assign w_sv_mem_addr = SAVE_BASE + sv_addr;

    // A real ack has precedence over a watchdog expiry in the same cycle.
    assign w_finish      = mem_ack || (wd_cnt_q == c_WD_LAST);
    assign w_rd_data     = mem_ack ? mem_dout : 8'hFF;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_sv_d   = last_sv_q;
        ld_full_d   = ld_full_q;
        ld_addr_d   = ld_addr_q;
        ld_data_d   = ld_data_q;
        mem_req_d   = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        cart_ack_d  = 1'b0;
        cart_dout_d = cart_dout_q;
        sv_ack_d    = 1'b0;
        sv_dout_d   = sv_dout_q;
        wd_cnt_d    = wd_cnt_q;
        terr_d      = terr_q;

        // Loader byte capture; a strobe while the buffer is full is dropped.
        if (ld_wr && !ld_full_q) begin
            ld_full_d = 1'b1;
            ld_addr_d = ld_addr;
            ld_data_d = ld_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (ld_full_q) begin
                    owner_d    = OWN_LD;
                    mem_we_d   = 1'b1;
                    mem_addr_d = ld_addr_q;
                    mem_din_d  = ld_data_q;
                    mem_req_d  = 1'b1;
                    wd_cnt_d   = 8'd0;
                    state_d    = ST_WAIT;
                end else if (w_pick_sv) begin
                    owner_d    = OWN_SV;
                    last_sv_d  = 1'b1;
                    mem_we_d   = sv_we;
                    mem_addr_d = w_sv_mem_addr;
                    mem_din_d  = sv_din;
                    mem_req_d  = 1'b1;
                    wd_cnt_d   = 8'd0;
                    state_d    = ST_WAIT;
                end else if (w_pick_cart) begin
                    owner_d    = OWN_CART;
                    last_sv_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    mem_addr_d = cart_addr;
                    mem_din_d  = 8'h00;
                    mem_req_d  = 1'b1;
                    wd_cnt_d   = 8'd0;
                    state_d    = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (w_finish) begin
                    state_d = ST_DONE;
                    if (!mem_ack) begin
                        terr_d = 1'b1;
                    end
                    // Acks are registered here so they are visible during DONE.
                    case (owner_q)
                        OWN_CART: begin
                            cart_ack_d  = 1'b1;
                            cart_dout_d = w_rd_data;
                        end
                        OWN_SV: begin
                            sv_ack_d = 1'b1;
                            if (!mem_we_q) begin
                                sv_dout_d = w_rd_data;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    wd_cnt_d = wd_cnt_q + 8'd1;
                end
            end

            ST_DONE: begin
                if (owner_q == OWN_LD) begin
                    ld_full_d = 1'b0;
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_LD;
            last_sv_q   <= 1'b0;       // cart counts as last served: sv wins first tie
            ld_full_q   <= 1'b0;
            ld_addr_q   <= '0;
            ld_data_q   <= 8'h00;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= 8'h00;
            cart_ack_q  <= 1'b0;
            cart_dout_q <= 8'h00;
            sv_ack_q    <= 1'b0;
            sv_dout_q   <= 8'h00;
            wd_cnt_q    <= 8'd0;
            terr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_sv_q   <= last_sv_d;
            ld_full_q   <= ld_full_d;
            ld_addr_q   <= ld_addr_d;
            ld_data_q   <= ld_data_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            cart_ack_q  <= cart_ack_d;
            cart_dout_q <= cart_dout_d;
            sv_ack_q    <= sv_ack_d;
            sv_dout_q   <= sv_dout_d;
            wd_cnt_q    <= wd_cnt_d;
            terr_q      <= terr_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ld_wait     = ld_full_q;
    assign cart_ack    = cart_ack_q;
    assign cart_dout   = cart_dout_q;
    assign sv_ack      = sv_ack_q;
    assign sv_dout     = sv_dout_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_din     = mem_din_q;
    assign timeout_err = terr_q;

endmodule
`default_nettype wire

// File: tb/tb_gba_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gba_mem_arbiter
// Purpose  : Self-checking bench for gba_mem_arbiter. A transaction-level
//            model predicts every output each cycle from grant/complete
//            cycle numbers; directed tests add hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gba_mem_arbiter;

    localparam int          ADDR_W    = 25;
    localparam int          TIMEOUT   = 255;
    localparam logic [24:0] SAVE_BASE = 25'h1F00000;

    logic              clk_sys = 1'b0;
    logic              reset_n = 1'b0;
    logic              downloading = 1'b0;
    logic              ld_wr = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [7:0]        ld_data = 8'h00;
    logic              ld_wait;
    logic              cart_req = 1'b0;
    logic [ADDR_W-1:0] cart_addr = '0;
    logic              cart_ack;
    logic [7:0]        cart_dout;
    logic              sv_req = 1'b0;
    logic              sv_we = 1'b0;
    logic [ADDR_W-1:0] sv_addr = '0;
    logic [7:0]        sv_din = 8'h00;
    logic              sv_ack;
    logic [7:0]        sv_dout;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic              mem_ack;
    logic [7:0]        mem_dout = 8'h00;
    logic              timeout_err;

    always #5 clk_sys = ~clk_sys;

    gba_mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .SAVE_BASE (SAVE_BASE),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .downloading (downloading),
        .ld_wr       (ld_wr),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_wait     (ld_wait),
        .cart_req    (cart_req),
        .cart_addr   (cart_addr),
        .cart_ack    (cart_ack),
        .cart_dout   (cart_dout),
        .sv_req      (sv_req),
        .sv_we       (sv_we),
        .sv_addr     (sv_addr),
        .sv_din      (sv_din),
        .sv_ack      (sv_ack),
        .sv_dout     (sv_dout),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_ack     (mem_ack),
        .mem_dout    (mem_dout),
        .timeout_err (timeout_err)
    );

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------------------------
    // SDRAM controller emulation: ack ctl_delay cycles after mem_req.
    // inj_ack lets the stimulus inject a stray ack.
    // ------------------------------------------------------------------------
    logic       ctl_en    = 1'b1;
    int         ctl_delay = 2;
    logic [7:0] ctl_rdata = 8'h00;
    logic       ctl_ack   = 1'b0;
    logic       inj_ack   = 1'b0;
    bit         ctl_pend  = 1'b0;
    int         ctl_cnt   = 0;

    assign mem_ack = ctl_ack | inj_ack;

    always @(negedge clk_sys) begin
        ctl_ack = 1'b0;
        if (!reset_n) begin
            ctl_pend = 1'b0;
        end else begin
            if (ctl_pend) begin
                if (ctl_cnt <= 1) begin
                    ctl_ack  = 1'b1;
                    mem_dout = ctl_rdata;
                    ctl_pend = 1'b0;
                end else begin
                    ctl_cnt--;
                end
            end
            if (mem_req && ctl_en) begin
                ctl_pend = 1'b1;
                ctl_cnt  = ctl_delay;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Transaction-level model. A transaction granted at edge g completes at
    // the first later edge that sees mem_ack, or at edge g+TIMEOUT. The owner
    // ack shows after that edge; the following edge releases the loader
    // buffer, and the edge after that is the earliest next grant.
    // ------------------------------------------------------------------------
    typedef struct {
        logic [24:0] addr;
        logic        we;
        logic [7:0]  din;
        int          cyc;
    } txn_t;

    txn_t        log_q[$];
    int          cyc = 0;
    int          last_cart_ack_cyc = -1;
    int          last_sv_ack_cyc   = -1;

    bit          m_busy = 1'b0;
    int          m_grant = 0;
    int          m_rel = -10;      // edge at which the finished transaction retires
    int          m_owner = 0;      // 0 loader, 1 cart, 2 save
    int          m_last_served = 1;
    logic        m_buf_full = 1'b0;
    logic [24:0] m_buf_addr = '0;
    logic [7:0]  m_buf_data = 8'h00;
    logic        m_mem_req = 1'b0, m_we = 1'b0;
    logic [24:0] m_addr = '0;
    logic [7:0]  m_din = 8'h00;
    logic        m_cart_ack = 1'b0, m_sv_ack = 1'b0, m_terr = 1'b0;
    logic [7:0]  m_cart_dout = 8'h00, m_sv_dout = 8'h00;

    always @(posedge clk_sys) begin
        logic       old_full;
        logic [7:0] rd;
        bit         take_sv;
        bit         ok;
        cyc++;
        if (!reset_n) begin
            m_busy = 1'b0; m_rel = -10; m_owner = 0; m_last_served = 1;
            m_buf_full = 1'b0; m_mem_req = 1'b0; m_we = 1'b0; m_addr = '0;
            m_din = 8'h00; m_cart_ack = 1'b0; m_sv_ack = 1'b0; m_terr = 1'b0;
            m_cart_dout = 8'h00; m_sv_dout = 8'h00;
        end else begin
            old_full   = m_buf_full;
            m_mem_req  = 1'b0;
            m_cart_ack = 1'b0;
            m_sv_ack   = 1'b0;
            if (m_busy && cyc > m_grant && (mem_ack || (cyc - m_grant) == TIMEOUT)) begin
                rd = mem_ack ? mem_dout : 8'hFF;
                if (!mem_ack) m_terr = 1'b1;
                if (m_owner == 1) begin
                    m_cart_ack = 1'b1; m_cart_dout = rd;
                end else if (m_owner == 2) begin
                    m_sv_ack = 1'b1;
                    if (!m_we) m_sv_dout = rd;
                end
                m_busy = 1'b0;
                m_rel  = cyc + 1;
            end
            if (!m_busy && cyc > m_rel) begin
                take_sv = sv_req && (!cart_req || m_last_served != 2);
                if (old_full) begin
                    m_owner = 0; m_we = 1'b1; m_addr = m_buf_addr; m_din = m_buf_data;
                    m_busy = 1'b1; m_grant = cyc; m_mem_req = 1'b1;
                end else if (!downloading && take_sv) begin
                    m_owner = 2; m_we = sv_we; m_addr = SAVE_BASE + sv_addr; m_din = sv_din;
                    m_last_served = 2; m_busy = 1'b1; m_grant = cyc; m_mem_req = 1'b1;
                end else if (!downloading && cart_req) begin
                    m_owner = 1; m_we = 1'b0; m_addr = cart_addr;
                    m_last_served = 1; m_busy = 1'b1; m_grant = cyc; m_mem_req = 1'b1;
                end
            end
            if (ld_wr && !old_full) begin
                m_buf_full = 1'b1; m_buf_addr = ld_addr; m_buf_data = ld_data;
            end
            if (cyc == m_rel && m_owner == 0) m_buf_full = 1'b0;
        end

        #1;
        ok = (mem_req === m_mem_req) && (cart_ack === m_cart_ack) &&
             (cart_dout === m_cart_dout) && (sv_ack === m_sv_ack) &&
             (sv_dout === m_sv_dout) && (ld_wait === m_buf_full) &&
             (timeout_err === m_terr);
        if (m_busy) begin
            ok = ok && (mem_we === m_we) && (mem_addr === m_addr) &&
                 (!m_we || mem_din === m_din);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL cycle_compare @%0d (got/exp): req=%b/%b we=%b/%b addr=%h/%h din=%h/%h cack=%b/%b cdout=%h/%h sack=%b/%b sdout=%h/%h wait=%b/%b terr=%b/%b",
                     cyc, mem_req, m_mem_req, mem_we, m_we, mem_addr, m_addr, mem_din, m_din,
                     cart_ack, m_cart_ack, cart_dout, m_cart_dout, sv_ack, m_sv_ack,
                     sv_dout, m_sv_dout, ld_wait, m_buf_full, timeout_err, m_terr);
        end
        if (mem_req === 1'b1) log_q.push_back('{mem_addr, mem_we, mem_din, cyc});
        if (cart_ack === 1'b1) last_cart_ack_cyc = cyc;
        if (sv_ack === 1'b1)   last_sv_ack_cyc   = cyc;
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ack(input bit is_sv, input int max_cyc, input string name);
        bit seen = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk_sys);
            if ((is_sv ? sv_ack : cart_ack) === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_ld_ready(input int max_cyc);
        bit seen = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            if (ld_wait === 1'b0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk_sys);
        end
        chk("ld_wait_release", {31'd0, seen}, 32'd1);
    endtask

    logic [7:0] ld_bytes [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic [24:0] rr_exp [4];

    initial begin : timeout_guard
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        bit seen;
        rr_exp[0] = 25'h1F00010; rr_exp[1] = 25'h0000200;
        rr_exp[2] = 25'h1F00010; rr_exp[3] = 25'h0000200;

        // ---------------- reset values ----------------
        repeat (3) @(negedge clk_sys);
        chk("rst_mem_req",  {31'd0, mem_req}, 32'd0);
        chk("rst_ld_wait",  {31'd0, ld_wait}, 32'd0);
        chk("rst_mem_addr", {7'd0, mem_addr}, 32'd0);
        chk("rst_douts",    {16'd0, cart_dout, sv_dout}, 32'd0);
        chk("rst_terr",     {31'd0, timeout_err}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        // ---------------- loader stream ----------------
        log_q.delete();
        ctl_delay   = 2;
        downloading = 1'b1;
        cart_req    = 1'b1;
        cart_addr   = 25'h55;
        for (int i = 0; i < 4; i++) begin
            wait_ld_ready(40);
            ld_addr = 25'(i);
            ld_data = ld_bytes[i];
            ld_wr   = 1'b1;
            @(negedge clk_sys);
            ld_wr = 1'b0;
            chk("ld_wait_pending", {31'd0, ld_wait}, 32'd1);
        end
        wait_ld_ready(40);
        repeat (6) @(negedge clk_sys);
        cart_req = 1'b0;
        chk("ld_count", log_q.size(), 32'd4);
        if (log_q.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("ld_addr", {7'd0, log_q[i].addr}, i);
                chk("ld_we_din", {23'd0, log_q[i].we, log_q[i].din}, {23'd0, 1'b1, ld_bytes[i]});
            end
        end
        @(negedge clk_sys);
        downloading = 1'b0;
        repeat (2) @(negedge clk_sys);

        // ---------------- cart read ----------------
        log_q.delete();
        ctl_delay = 4; ctl_rdata = 8'h5A;
        cart_addr = 25'h000100; cart_req = 1'b1;
        wait_ack(1'b0, 40, "cart_ack_seen");
        cart_req = 1'b0;
        chk("cart_dout", {24'd0, cart_dout}, 32'h5A);
        chk("cart_req_count", log_q.size(), 32'd1);
        if (log_q.size() >= 1) begin
            chk("cart_addr_we", {6'd0, log_q[0].we, log_q[0].addr}, 32'h100);
            chk("cart_latency", last_cart_ack_cyc - log_q[0].cyc, 32'd5);
        end
        repeat (3) @(negedge clk_sys);

        // ---------------- round robin ----------------
        log_q.delete();
        ctl_delay = 2; ctl_rdata = 8'h11;
        sv_we = 1'b0; sv_addr = 25'h10; cart_addr = 25'h200;
        sv_req = 1'b1; cart_req = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk_sys);
            if (log_q.size() >= 4) begin seen = 1'b1; break; end
        end
        sv_req = 1'b0; cart_req = 1'b0;
        chk("rr_four_grants", {31'd0, seen}, 32'd1);
        repeat (10) @(negedge clk_sys);
        chk("rr_count", log_q.size(), 32'd4);
        if (log_q.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("rr_order_addr", {7'd0, log_q[i].addr}, {7'd0, rr_exp[i]});
        end

        // ---------------- save write with address wrap, then save read ----------------
        log_q.delete();
        sv_we = 1'b1; sv_addr = 25'h0FFFFF0; sv_din = 8'h3C; sv_req = 1'b1;
        wait_ack(1'b1, 40, "sv_wr_ack_seen");
        sv_req = 1'b0;
        if (log_q.size() >= 1) begin
            chk("sv_wrap_addr", {7'd0, log_q[0].addr}, 32'h0EFFFF0);
            chk("sv_wr_we_din", {23'd0, log_q[0].we, log_q[0].din}, {23'd0, 9'h13C});
        end
        repeat (2) @(negedge clk_sys);
        log_q.delete();
        ctl_rdata = 8'h77;
        sv_we = 1'b0; sv_addr = 25'h5; sv_req = 1'b1;
        wait_ack(1'b1, 40, "sv_rd_ack_seen");
        sv_req = 1'b0;
        chk("sv_rd_dout", {24'd0, sv_dout}, 32'h77);
        if (log_q.size() >= 1) chk("sv_rd_addr", {7'd0, log_q[0].addr}, 32'h1F00005);
        repeat (2) @(negedge clk_sys);

        // ---------------- watchdog + stray late ack ----------------
        log_q.delete();
        ctl_en = 1'b0;
        cart_addr = 25'h300; cart_req = 1'b1;
        wait_ack(1'b0, 300, "wd_ack_seen");
        cart_req = 1'b0;
        chk("wd_dout", {24'd0, cart_dout}, 32'hFF);
        chk("wd_terr", {31'd0, timeout_err}, 32'd1);
        if (log_q.size() >= 1) chk("wd_latency", last_cart_ack_cyc - log_q[0].cyc, 32'd255);
        repeat (2) @(negedge clk_sys);
        inj_ack = 1'b1;
        @(negedge clk_sys);
        inj_ack = 1'b0;
        repeat (5) @(negedge clk_sys);
        chk("wd_terr_sticky", {31'd0, timeout_err}, 32'd1);
        chk("late_ack_no_req", log_q.size(), 32'd1);

        // ---------------- reset mid-WAIT ----------------
        log_q.delete();
        cart_addr = 25'h400; cart_req = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_sys);
            if (mem_req === 1'b1) begin seen = 1'b1; break; end
        end
        chk("rstw_req_seen", {31'd0, seen}, 32'd1);
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b0;
        #1;
        chk("rstw_outs", {27'd0, mem_req, cart_ack, sv_ack, ld_wait, timeout_err}, 32'd0);
        chk("rstw_addr", {7'd0, mem_addr}, 32'd0);
        @(negedge clk_sys);
        cart_req = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        ctl_en = 1'b1; ctl_delay = 2; ctl_rdata = 8'h99;
        @(negedge clk_sys);
        log_q.delete();
        cart_addr = 25'h404; cart_req = 1'b1;
        wait_ack(1'b0, 40, "post_rst_ack_seen");
        cart_req = 1'b0;
        chk("post_rst_dout", {24'd0, cart_dout}, 32'h99);
        if (log_q.size() >= 1) begin
            chk("post_rst_addr", {7'd0, log_q[0].addr}, 32'h404);
            chk("post_rst_latency", last_cart_ack_cyc - log_q[0].cyc, 32'd3);
        end
        repeat (2) @(negedge clk_sys);

        // ---------------- mem_ack coincides with the watchdog limit ----------------
        log_q.delete();
        ctl_delay = 254; ctl_rdata = 8'h6B;
        cart_addr = 25'h500; cart_req = 1'b1;
        wait_ack(1'b0, 300, "edge_ack_seen");
        cart_req = 1'b0;
        chk("edge_dout", {24'd0, cart_dout}, 32'h6B);
        chk("edge_no_terr", {31'd0, timeout_err}, 32'd0);
        if (log_q.size() >= 1) chk("edge_latency", last_cart_ack_cyc - log_q[0].cyc, 32'd255);
        repeat (4) @(negedge clk_sys);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
